// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, derived totals/sync windows and the coordinate type.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  typedef logic [9:0] coord_t;

  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up counter with enable; exposes next-state value and a wrap flag
// so downstream registers can align with the counter's new value.
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int MOD = H_TOTAL_DEF
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output coord_t count_nxt,
  output logic   wrap
);

  assign wrap = en && (count == coord_t'(MOD - 1));

  always_comb begin
    count_nxt = count;
    if (wrap)
      count_nxt = '0;
    else if (en)
      count_nxt = count + coord_t'(1);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, active-low syncs, blank, line/frame strobes, frame counter.
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank one clock behind DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  coord_t hc, vc, hc_nxt, vc_nxt;
  logic   h_wrap, v_wrap;
  logic   hs_q, vs_q, blank_q;

  wrap_counter #(.MOD(H_TOTAL)) u_hc (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .en        (1'b1),
    .count     (hc),
    .count_nxt (hc_nxt),
    .wrap      (h_wrap)
  );

  wrap_counter #(.MOD(V_TOTAL)) u_vc (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .en        (h_wrap),
    .count     (vc),
    .count_nxt (vc_nxt),
    .wrap      (v_wrap)
  );

  assign DrawX = hc;
  assign DrawY = vc;
  assign sync  = 1'b0;

  // Decoded from next-state counters so the registered flags line up with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hs_q        <= !in_window(hc_nxt, HS_START, HS_END);
      vs_q        <= !in_window(vc_nxt, VS_START, VS_END);
      blank_q     <= (int'(hc_nxt) < H_ACTIVE) && (int'(vc_nxt) < V_ACTIVE);
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
      if (h_wrap && v_wrap)
        frame_count <= frame_count + 8'd1;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d, blank_d;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_d <= 1'b0;
    end else begin
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      blank_d <= blank_q;
    end
  end

  assign hs    = hs_d;
  assign vs    = vs_d;
  assign blank = blank_d;
`else
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-geometry instance with random resets and a long run past the
// frame_count wrap, plus a default-geometry instance with a mid-line asynchronous reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct packed {
    out_t s;
    out_t d;
  } exp_t;

  logic vga_clk = 1'b0;
  logic rst_s, rst_d;

  logic       s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;
  logic       d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  exp_t   q[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     abort = 0;
  longint n_s = 0;
  longint n_d = 0;
  int     d_hold = 2;
  bit     d_done = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .vga_clk(vga_clk), .reset(rst_s), .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync),
    .DrawX(s_x), .DrawY(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen dut_def (
    .vga_clk(vga_clk), .reset(rst_d), .hs(d_hs), .vs(d_vs), .blank(d_blank), .sync(d_sync),
    .DrawX(d_x), .DrawY(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  // Raster position as a pure function of clock edges seen since reset release.
  function automatic out_t raster(input longint n, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb);
    out_t   o;
    longint ht, vt, ft, pos, x, y;
    o = '0;
    if (n == 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      return o;
    end
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    ft   = ht * vt;
    pos  = n % ft;
    x    = pos % ht;
    y    = pos / ht;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.hs = !(x >= ha + hf && x < ha + hf + hsw);
    o.vs = !(y >= va + vf && y < va + vf + vsw);
    o.blank = (x < ha) && (y < va);
    o.ls = (x == 0);
    o.fs = (pos == 0);
    o.fc = 8'((n / ft) % 256);
    return o;
  endfunction

  function automatic out_t ref_out(input longint n, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb);
    out_t o;
    o = raster(n, ha, hf, hsw, hb, va, vf, vsw, vb);
`ifdef VGA_SYNC_DELAY_EN
    begin
      out_t p;
      p = raster((n == 0) ? 0 : n - 1, ha, hf, hsw, hb, va, vf, vsw, vb);
      o.hs    = p.hs;
      o.vs    = p.vs;
      o.blank = p.blank;
    end
`endif
    return o;
  endfunction

  task automatic step(input bit r_s);
    exp_t e;
    @(posedge vga_clk);
    if (rst_s) n_s = 0; else n_s++;
    if (rst_d) n_d = 0; else n_d++;
    #1;
    rst_s = r_s;
    if (r_s) n_s = 0;
    if (d_hold > 0) d_hold--;
    else if (!d_done && n_d == 1100) begin  // DrawX=300, DrawY=1
      d_hold = 2;
      d_done = 1;
    end
    rst_d = (d_hold > 0);
    if (rst_d) n_d = 0;
    e.s = ref_out(n_s, 8, 2, 2, 2, 4, 1, 1, 1);
    e.d = ref_out(n_d, 640, 16, 96, 48, 480, 10, 2, 33);
    q.push_back(e);
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t act hs=%b vs=%b blank=%b sync=%b x=%0d y=%0d ls=%b fs=%b fc=%0d | exp hs=%b vs=%b blank=%b sync=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               name, $time, act.hs, act.vs, act.blank, act.sync, act.x, act.y, act.ls, act.fs, act.fc,
               exp.hs, exp.vs, exp.blank, exp.sync, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
      if (miscompares >= 40) abort = 1;
    end
  endtask

  always @(negedge vga_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("small", {s_hs, s_vs, s_blank, s_sync, s_x, s_y, s_ls, s_fs, s_fc}, e.s);
      check("default", {d_hs, d_vs, d_blank, d_sync, d_x, d_y, d_ls, d_fs, d_fc}, e.d);
    end
  end

  initial begin
    int hold;
    rst_s = 1'b1;
    rst_d = 1'b1;
    hold  = 2;
    // Short random runs interrupted by asynchronous resets of 1..3 cycles.
    for (int c = 0; c < 3000 && !abort; c++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 299) == 0) hold = $urandom_range(1, 3);
      step(hold > 0);
    end
    // Uninterrupted run past 256 small frames to cross the frame_count wrap.
    if (!abort) begin
      step(1'b1);
      step(1'b1);
    end
    for (int c = 0; c < 98 * 260 && !abort; c++) step(1'b0);
    repeat (2) @(negedge vga_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
